// File: rtl/phase_frequency_detector_loop_filter_if.sv
// PFD/loop-filter signal bundle: sampled clocks in,
// VCO control voltage and status flags out.
interface phase_frequency_detector_loop_filter_if;
   logic       ref_clock_digital;
   logic       fb_clock_digital;
   logic [9:0] output_voltage_real;
   logic       up_digital;
   logic       down_digital;
   logic       lock_digital;

   modport master (
      output ref_clock_digital,
      output fb_clock_digital,
      input  output_voltage_real,
      input  up_digital,
      input  down_digital,
      input  lock_digital
   );

   modport slave (
      input  ref_clock_digital,
      input  fb_clock_digital,
      output output_voltage_real,
      output up_digital,
      output down_digital,
      output lock_digital
   );
endinterface

// File: rtl/phase_frequency_detector_loop_filter.sv
// Three-state PFD, saturating charge-pump integrator with
// proportional kick, and narrow-pulse lock detector.
module phase_frequency_detector_loop_filter #(
   parameter int ICP        = 16,
   parameter int KP         = 8,
   parameter int INIT_V     = 512,
   parameter int LOCK_COUNT = 8,
   parameter int LOCK_WIN   = 2
) (
   input logic clk,
   input logic reset,
   phase_frequency_detector_loop_filter_if.slave pfd
);

   localparam int CW = $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {IDLE, UP, DN} state_t;

   state_t state, state_nxt;

   logic          ref_q, fb_q;
   logic          ref_edge, fb_edge;
   logic [15:0]   integ, integ_nxt;
   logic [16:0]   integ_sum;
   logic [7:0]    width, width_inc;
   logic [CW-1:0] lock_cnt;
   logic [9:0]    vout, v_nxt;
   logic          up, down, lock;
   logic signed [11:0] p_term, v_sum;

   assign ref_edge = pfd.ref_clock_digital & ~ref_q;
   assign fb_edge  = pfd.fb_clock_digital & ~fb_q;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (ref_edge & ~fb_edge)
               state_nxt = UP;
            else if (fb_edge & ~ref_edge)
               state_nxt = DN;
         end
         UP:      if (fb_edge) state_nxt = IDLE;
         DN:      if (ref_edge) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // 17-bit sum so carry/borrow out drives the clamp
   always_comb begin
      integ_sum = {1'b0, integ};
      integ_nxt = integ;
      if (state == UP) begin
         integ_sum = {1'b0, integ} + 17'(ICP);
         integ_nxt = integ_sum[16] ? 16'hFFFF : integ_sum[15:0];
      end else if (state == DN) begin
         integ_sum = {1'b0, integ} - 17'(ICP);
         integ_nxt = integ_sum[16] ? 16'h0000 : integ_sum[15:0];
      end
   end

   always_comb begin
      p_term = '0;
      if (state == UP)
         p_term = 12'(KP);
      else if (state == DN)
         p_term = -(12'(KP));
      v_sum = $signed({2'b00, integ[15:6]}) + p_term;
      if (v_sum[11])
         v_nxt = '0;
      else if (v_sum > 12'sd1023)
         v_nxt = '1;
      else
         v_nxt = v_sum[9:0];
   end

   assign width_inc = (width == 8'hFF) ? width : width + 8'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ref_q    <= 1'b0;
         fb_q     <= 1'b0;
         state    <= IDLE;
         integ    <= 16'(INIT_V << 6);
         vout     <= 10'(INIT_V);
         up       <= 1'b0;
         down     <= 1'b0;
         lock     <= 1'b0;
         width    <= '0;
         lock_cnt <= '0;
      end else begin
         ref_q <= pfd.ref_clock_digital;
         fb_q  <= pfd.fb_clock_digital;
         state <= state_nxt;
         integ <= integ_nxt;
         vout  <= v_nxt;
         up    <= (state_nxt == UP);
         down  <= (state_nxt == DN);
         lock  <= (lock_cnt == CW'(LOCK_COUNT));
         if (state != IDLE && state_nxt != IDLE)
            width <= width_inc;
         else
            width <= '0;
         // width_inc is the pulse length including this cycle
         if (state != IDLE) begin
            if (width_inc > 8'(LOCK_WIN))
               lock_cnt <= '0;
            else if (state_nxt == IDLE &&
                     lock_cnt != CW'(LOCK_COUNT))
               lock_cnt <= lock_cnt + 1'b1;
         end
      end
   end

   assign pfd.output_voltage_real = vout;
   assign pfd.up_digital          = up;
   assign pfd.down_digital        = down;
   assign pfd.lock_digital        = lock;

endmodule

// File: tb/tb_phase_frequency_detector_loop_filter.sv
// Bench for the PFD/loop filter: vector table with queue
// scoreboard plus hand sequences for saturation and lock.
module tb_phase_frequency_detector_loop_filter;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   phase_frequency_detector_loop_filter_if pfd ();

   phase_frequency_detector_loop_filter dut (
      .clk   (clk),
      .reset (reset),
      .pfd   (pfd)
   );

   typedef struct {
      logic       r;
      logic       f;
      logic [9:0] out;
      logic       up;
      logic       dn;
   } vec_t;

   vec_t tbl[18];
   vec_t sb[$];
   vec_t e;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic f);
      pfd.ref_clock_digital = r;
      pfd.fb_clock_digital  = f;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pfd.ref_clock_digital = 1'b0;
      pfd.fb_clock_digital  = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // one PFD pulse: ref edge, fb edge d cycles later, 20-cycle period
   task automatic pulse(input int d);
      cyc(1'b1, 1'b0);
      for (int i = 1; i < d; i++) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      repeat (9 - d) cyc(1'b1, 1'b1);
      repeat (10) cyc(1'b0, 1'b0);
   endtask

   initial begin
      int bad;
      int prev;

      // ref rises at cycle 10; record k holds cycle-k inputs and
      // the outputs seen during cycle k+1
      for (int k = 0; k < 18; k++) begin
         tbl[k].r  = (k >= 10);
         tbl[k].f  = 1'b0;
         tbl[k].up = (k >= 10);
         tbl[k].dn = 1'b0;
         if (k <= 10)
            tbl[k].out = 10'd512;
         else if (k <= 14)
            tbl[k].out = 10'd520;
         else
            tbl[k].out = 10'd521;
      end

      pfd.ref_clock_digital = 1'b0;
      pfd.fb_clock_digital  = 1'b0;
      #12;
      chk("rst_out", pfd.output_voltage_real, 512);
      chk("rst_up", pfd.up_digital, 0);
      chk("rst_dn", pfd.down_digital, 0);
      chk("rst_lock", pfd.lock_digital, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      bad = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1'b0, 1'b0);
         if (pfd.output_voltage_real !== 10'd512) bad++;
      end
      chk("idle_hold_dev", bad, 0);
      chk("idle_hold_out", pfd.output_voltage_real, 512);

      for (int k = 0; k < 18; k++) begin
         pfd.ref_clock_digital = tbl[k].r;
         pfd.fb_clock_digital  = tbl[k].f;
         sb.push_back(tbl[k]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("vec%0d_out", k), pfd.output_voltage_real, e.out);
         chk($sformatf("vec%0d_up", k), pfd.up_digital, e.up);
         chk($sformatf("vec%0d_dn", k), pfd.down_digital, e.dn);
      end

      bad = 0;
      prev = pfd.output_voltage_real;
      for (int i = 0; i < 2200; i++) begin
         cyc(1'b1, 1'b0);
         if (pfd.output_voltage_real < prev) bad++;
         prev = pfd.output_voltage_real;
      end
      chk("up_sat_monotonic", bad, 0);
      chk("up_sat_out", pfd.output_voltage_real, 1023);
      chk("up_sat_up", pfd.up_digital, 1);
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      chk("up_sat_idle_up", pfd.up_digital, 0);
      chk("up_sat_integ", pfd.output_voltage_real, 1023);

      do_reset();
      chk("rst2_out", pfd.output_voltage_real, 512);
      bad = 0;
      prev = pfd.output_voltage_real;
      for (int i = 0; i < 2200; i++) begin
         cyc(1'b0, 1'b1);
         if (pfd.output_voltage_real > prev) bad++;
         prev = pfd.output_voltage_real;
      end
      chk("dn_sat_monotonic", bad, 0);
      chk("dn_sat_out", pfd.output_voltage_real, 0);
      chk("dn_sat_dn", pfd.down_digital, 1);
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      chk("dn_sat_idle_dn", pfd.down_digital, 0);
      chk("dn_sat_integ", pfd.output_voltage_real, 0);

      do_reset();
      repeat (3) cyc(1'b0, 1'b0);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b1);
         if (pfd.up_digital || pfd.down_digital ||
             pfd.output_voltage_real !== 10'd512) bad++;
      end
      chk("both_edges_dev", bad, 0);
      chk("both_edges_out", pfd.output_voltage_real, 512);

      do_reset();
      repeat (3) cyc(1'b0, 1'b0);
      repeat (6) cyc(1'b1, 1'b0);
      chk("mid_pulse_up", pfd.up_digital, 1);
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst_out", pfd.output_voltage_real, 512);
      chk("async_rst_up", pfd.up_digital, 0);
      pfd.ref_clock_digital = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) cyc(1'b0, 1'b0);
      chk("after_abort_out", pfd.output_voltage_real, 512);

      do_reset();
      repeat (5) cyc(1'b0, 1'b0);
      repeat (7) pulse(1);
      chk("lock_after7", pfd.lock_digital, 0);
      pulse(1);
      chk("lock_after8", pfd.lock_digital, 1);
      chk("integ_8pulses", pfd.output_voltage_real, 514);

      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("wide_lock_hold", pfd.lock_digital, 1);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("wide_lock_drop", pfd.lock_digital, 0);
      cyc(1'b1, 1'b1);
      repeat (4) cyc(1'b1, 1'b1);
      repeat (10) cyc(1'b0, 1'b0);
      chk("wide_idle_up", pfd.up_digital, 0);

      repeat (7) pulse(1);
      chk("relock_after7", pfd.lock_digital, 0);
      pulse(1);
      chk("relock_after8", pfd.lock_digital, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/phase_frequency_detector_loop_filter.md
Name: phase_frequency_detector_loop_filter

Overview:
- Upstream stage of voltage_controled_oscillator in the PLL benchmark; drives its 10-bit control input `input_voltage_real`.
- Compares rising edges of the reference clock and the divided VCO feedback, both carried as sampled 1-bit data signals in the `clk` domain.
- Three-state PFD drives a saturating charge-pump integrator plus a proportional term, giving a registered 10-bit unsigned control voltage.
- Also flags lock when phase-error pulses stay narrow.

Parameters:
ICP, 16, integrator step per cycle in UP/DN (integrator LSBs; 6 fractional bits)
KP, 8, proportional offset added (UP) or subtracted (DN) at output LSB scale
INIT_V, 512, integrator and output reset value in output LSBs (0..1023)
LOCK_COUNT, 8, consecutive narrow pulses required to assert lock
LOCK_WIN, 2, max pulse width in cycles that counts as narrow

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ref_clock_digital  input  1  sampled reference clock
fb_clock_digital  input  1  sampled divided VCO clock
output_voltage_real  output  10  control voltage to VCO, unsigned
up_digital  output  1  high while PFD state is UP
down_digital  output  1  high while PFD state is DN
lock_digital  output  1  lock indicator

Behaviour:
- Reset (reset=0, async), all values forced immediately:
  - ref_q=fb_q=0; state=IDLE.
  - integ (16b unsigned) = INIT_V<<6 (32768 by default); output_voltage_real=INIT_V.
  - up/down/lock=0; width=0; lock_cnt=0.
- Edge detect (combinational, cycle n): ref_edge = ref_clock_digital & ~ref_q; fb_edge = fb_clock_digital & ~fb_q. ref_q/fb_q register the inputs each cycle.
- PFD FSM, registered at end of cycle n:
  - IDLE: ref_edge&~fb_edge -> UP; fb_edge&~ref_edge -> DN; both or neither -> IDLE.
  - UP: fb_edge -> IDLE (regardless of ref_edge); else UP.
  - DN: ref_edge -> IDLE (regardless of fb_edge); else DN.
  - up_digital = (state==UP); down_digital = (state==DN); both registered, never high together.
- Integrator, uses registered state:
  - UP: integ <= min(integ+ICP, 65535).
  - DN: integ <= max(integ-ICP, 0).
  - IDLE: hold.
  - Compute in 17 bits, then clamp.
- Output register: output_voltage_real <= clamp((integ>>6) + P, 0, 1023), where P = +KP in UP, -KP in DN, 0 in IDLE. Uses registered integ and state; compute in signed 12 bits.
- Latency from an edge in cycle n:
  - state changes at n+1;
  - proportional step visible on output at n+2;
  - first integrator contribution visible at n+3.
- Width counter (8b, saturating at 255):
  - increments each cycle state≠IDLE;
  - resets to 0 on the transition into IDLE.
- Lock:
  - On UP/DN->IDLE with final width ≤ LOCK_WIN: lock_cnt <= min(lock_cnt+1, LOCK_COUNT).
  - If width exceeds LOCK_WIN while in UP/DN: lock_cnt <= 0 that cycle.
  - lock_digital registered = (lock_cnt==LOCK_COUNT); drops one cycle after lock_cnt clears.
- Async reset mid-pulse abandons the pulse; no partial integration is retained.

Test Plan:
- Reset with defaults -> output_voltage_real=512, up/down/lock=0; hold inputs 0 for 50 cycles -> output stays 512.
- Single ref rising edge at cycle 10, fb never toggles:
  - up_digital=1 from cycle 11;
  - output=520 at cycle 12;
  - integ +16 per cycle, so output reaches 521 after four integrating cycles.
- Continue UP indefinitely -> integ saturates at 65535 and output clamps at 1023 (not 1031); no wrap. Mirror with fb-only edges -> output clamps at 0, integ at 0.
- ref and fb rising edges in the same cycle from IDLE -> state stays IDLE, output unchanged at 512.
- Periodic edges every 20 cycles, fb 1 cycle after ref:
  - each 1-cycle UP pulse adds 16 to integ;
  - lock_digital asserts after the 8th pulse completes.
- Then delay fb to 5 cycles after ref -> lock_digital deasserts within the 3rd cycle of that UP pulse (+1 register); re-lock after 8 further 1-cycle pulses.
